// File: rtl/frame_tick_gen.sv
// Programmable base tick generator with NUM_CH divided tick channels, each optionally one-shot.
// Define FRAME_TICK_GEN_FRAME_COUNT_EN to build the 16-bit frame counter; otherwise frame_count reads 0.
module frame_tick_gen #(
   parameter int CNT_W  = 22,
   parameter int PERIOD = 2000000,
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      restart,
   input  logic [CNT_W-1:0]          period_in,
   input  logic                      period_wr,
   input  logic [NUM_CH*DIV_W-1:0]   ch_div,
   input  logic [NUM_CH-1:0]         ch_oneshot,
   input  logic [NUM_CH-1:0]         ch_arm,
   output logic                      base_tick,
   output logic [NUM_CH-1:0]         ch_tick,
   output logic [15:0]               frame_count
);

   logic [CNT_W-1:0]  period_reg;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  period_ld;
   logic              wrap;
   logic [DIV_W-1:0]  ch_cnt     [NUM_CH];
   logic [DIV_W-1:0]  ch_cnt_nxt [NUM_CH];
   logic [DIV_W-1:0]  d_eff      [NUM_CH];
   logic [NUM_CH-1:0] disarmed;
   logic [NUM_CH-1:0] disarmed_nxt;
   logic [NUM_CH-1:0] ch_fire;

   // Periods below 2 are clamped so a tick can never be back-to-back with a load.
   assign period_ld = (period_in < CNT_W'(2)) ? CNT_W'(2) : period_in;

   // The wrap cycle is the only cycle that can produce any tick; restart and loads suppress it.
   assign wrap = enable && !restart && !period_wr && (cnt >= period_reg - CNT_W'(1));

   always_ff @(posedge clock) begin
      if (reset) begin
         period_reg <= CNT_W'(PERIOD);
         cnt        <= '0;
         base_tick  <= 1'b0;
      end else begin
         base_tick <= wrap;
         if (restart || period_wr) begin
            cnt <= '0;
            if (period_wr)
               period_reg <= period_ld;
         end else if (enable) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         d_eff[i]        = (ch_div[i*DIV_W +: DIV_W] == '0) ? DIV_W'(1) : ch_div[i*DIV_W +: DIV_W];
         ch_cnt_nxt[i]   = ch_cnt[i];
         disarmed_nxt[i] = disarmed[i] & ch_oneshot[i];
         ch_fire[i]      = 1'b0;
         if (ch_arm[i]) begin
            // An arm on a firing cycle wins: no tick, channel left armed from zero.
            disarmed_nxt[i] = 1'b0;
            ch_cnt_nxt[i]   = '0;
         end else if (wrap) begin
            if (disarmed_nxt[i]) begin
               ch_cnt_nxt[i] = '0;
            end else if (ch_cnt[i] >= d_eff[i] - DIV_W'(1)) begin
               ch_fire[i]      = 1'b1;
               ch_cnt_nxt[i]   = '0;
               disarmed_nxt[i] = ch_oneshot[i];
            end else begin
               ch_cnt_nxt[i] = ch_cnt[i] + DIV_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset || restart) begin
         for (int i = 0; i < NUM_CH; i++)
            ch_cnt[i] <= '0;
         disarmed <= '0;
         ch_tick  <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            ch_cnt[i] <= ch_cnt_nxt[i];
         disarmed <= disarmed_nxt;
         ch_tick  <= ch_fire;
      end
   end

`ifdef FRAME_TICK_GEN_FRAME_COUNT_EN
   // Restart deliberately leaves the frame count running.
   always_ff @(posedge clock) begin
      if (reset)
         frame_count <= 16'h0000;
      else if (wrap)
         frame_count <= frame_count + 16'd1;
   end
`else
   assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_tick_gen.sv
// Bench for frame_tick_gen (PERIOD=10, NUM_CH=2, DIV_W=4): per-cycle scoreboard plus a phase table
// of hand-derived tick counts and a few hand-written corner sequences.
module tb_frame_tick_gen;

   localparam int CNT_W  = 22;
   localparam int PERIOD = 10;
   localparam int NUM_CH = 2;
   localparam int DIV_W  = 4;
`ifdef FRAME_TICK_GEN_FRAME_COUNT_EN
   localparam bit FC_EN = 1'b1;
`else
   localparam bit FC_EN = 1'b0;
`endif

   logic                    clock = 1'b0;
   logic                    reset;
   logic                    enable;
   logic                    restart;
   logic [CNT_W-1:0]        period_in;
   logic                    period_wr;
   logic [NUM_CH*DIV_W-1:0] ch_div;
   logic [NUM_CH-1:0]       ch_oneshot;
   logic [NUM_CH-1:0]       ch_arm;
   logic                    base_tick;
   logic [NUM_CH-1:0]       ch_tick;
   logic [15:0]             frame_count;

   frame_tick_gen #(.CNT_W(CNT_W), .PERIOD(PERIOD), .NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
      .clock(clock), .reset(reset), .enable(enable), .restart(restart),
      .period_in(period_in), .period_wr(period_wr), .ch_div(ch_div),
      .ch_oneshot(ch_oneshot), .ch_arm(ch_arm), .base_tick(base_tick),
      .ch_tick(ch_tick), .frame_count(frame_count)
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   int m_period, m_cnt, m_fc;
   int m_chcnt [NUM_CH];
   bit m_dis   [NUM_CH];

   task automatic model_step(output logic [18:0] e);
      logic       bt;
      logic [1:0] ct;
      int         d;
      bt = 1'b0;
      ct = 2'b00;
      if (reset) begin
         m_period = PERIOD; m_cnt = 0; m_fc = 0;
         for (int i = 0; i < NUM_CH; i++) begin m_chcnt[i] = 0; m_dis[i] = 0; end
      end else if (restart) begin
         if (period_wr) m_period = (int'(period_in) < 2) ? 2 : int'(period_in);
         m_cnt = 0;
         for (int i = 0; i < NUM_CH; i++) begin m_chcnt[i] = 0; m_dis[i] = 0; end
      end else begin
         if (period_wr) begin
            m_period = (int'(period_in) < 2) ? 2 : int'(period_in);
            m_cnt = 0;
         end else if (enable) begin
            m_cnt++;
            if (m_cnt >= m_period) begin
               m_cnt = 0; bt = 1'b1; m_fc = (m_fc + 1) % 65536;
            end
         end
         for (int i = 0; i < NUM_CH; i++) begin
            d = int'(ch_div[i*DIV_W +: DIV_W]);
            if (d == 0) d = 1;
            if (!ch_oneshot[i]) m_dis[i] = 0;
            if (ch_arm[i]) begin
               m_dis[i] = 0; m_chcnt[i] = 0;
            end else if (bt && !m_dis[i]) begin
               m_chcnt[i]++;
               if (m_chcnt[i] >= d) begin
                  ct[i] = 1'b1; m_chcnt[i] = 0;
                  if (ch_oneshot[i]) m_dis[i] = 1;
               end
            end
         end
      end
      e = {bt, ct, (FC_EN ? 16'(m_fc) : 16'h0000)};
   endtask

   // ---------------- scoreboard ----------------
   logic [18:0] exp_q [$];
   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int seen_bt, seen_c0, seen_c1;

   task automatic cycle();
      logic [18:0] e, g;
      model_step(e);
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      cyc++;
      g = {base_tick, ch_tick, frame_count};
      e = exp_q.pop_front();
      n_vec++;
      if (g !== e) begin
         n_err++;
         $display("FAIL cyc%0d outputs: got bt=%b ct=%b fc=%0d, want bt=%b ct=%b fc=%0d",
                  cyc, g[18], g[17:16], g[15:0], e[18], e[17:16], e[15:0]);
      end
      seen_bt += int'(base_tick);
      seen_c0 += int'(ch_tick[0]);
      seen_c1 += int'(ch_tick[1]);
   endtask

   task automatic check(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // ---------------- phase table ----------------
   // restart/period_wr/arm apply to the first cycle of a row only; counts are ticks seen over the row.
   typedef struct {
      int rs, pw, pin, en, d1, d0, os, arm, n, bt, c0, c1;
   } vec_t;
   vec_t tbl [$];

   function automatic vec_t mk(int rs, int pw, int pin, int en, int d1, int d0,
                               int os, int arm, int n, int bt, int c0, int c1);
      vec_t v;
      v = '{rs, pw, pin, en, d1, d0, os, arm, n, bt, c0, c1};
      return v;
   endfunction

   initial begin
      reset = 1'b1; enable = 1'b0; restart = 1'b0; period_in = '0; period_wr = 1'b0;
      ch_div = '0; ch_oneshot = '0; ch_arm = '0;
      seen_bt = 0; seen_c0 = 0; seen_c1 = 0;

      //              rs pw pin en d1 d0 os arm  n  bt c0 c1
      // ticks exactly at enabled cycles 10, 20, 30
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  9, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  1, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  9, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  1, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  9, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  1, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  5, 0, 0, 0));
      // divide by 3 on ch1 over 60 enabled cycles
      tbl.push_back(mk(1, 0, 0, 1, 3, 0, 0, 0, 61, 6, 6, 2));
      // enable gap of 7 cycles delays the tick
      tbl.push_back(mk(1, 0, 0, 1, 3, 0, 0, 0,  5, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0,  7, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0,  5, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0,  1, 1, 1, 0));
      // one-shot ch1 with divisor 2
      tbl.push_back(mk(1, 0, 0, 1, 2, 0, 2, 0, 21, 2, 2, 1));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 2, 0, 40, 4, 4, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 2, 0,  9, 0, 0, 0));
      // re-arm, then arm on the firing cycle
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 2, 2,  1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 2, 0, 20, 2, 2, 1));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 2, 2,  1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 2, 0,  9, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 2, 0,  9, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 2, 2,  1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 2, 0, 20, 2, 2, 1));
      // restart on the expected tick cycle
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 2, 0,  9, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 2, 0, 2, 0,  1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 2, 0,  9, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 2, 0,  1, 1, 1, 0));
      // period loads: 1 and 0 clamp to 2, then 5, then restart+load 3
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0,  5, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  6, 3, 3, 3));
      tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  4, 2, 2, 2));
      tbl.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0,  1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 10, 2, 2, 2));
      tbl.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0,  1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  3, 1, 1, 1));
      // lowering the divisor below the current count fires on the next tick
      tbl.push_back(mk(1, 0, 0, 1, 4, 0, 0, 0,  1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 4, 0, 0, 0,  9, 3, 3, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0,  3, 1, 1, 1));
      // clearing one-shot mode re-enables a disarmed channel
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 2, 0,  3, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 2, 0,  3, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0,  3, 1, 1, 1));

      // clock/reset
      repeat (3) cycle();
      check("reset bt", int'(base_tick), 0);
      check("reset ct", int'(ch_tick), 0);
      check("reset fc", int'(frame_count), 0);
      reset = 1'b0;

      for (int r = 0; r < tbl.size(); r++) begin
         seen_bt = 0; seen_c0 = 0; seen_c1 = 0;
         enable     = tbl[r].en[0];
         ch_div     = {4'(tbl[r].d1), 4'(tbl[r].d0)};
         ch_oneshot = 2'(tbl[r].os);
         restart    = tbl[r].rs[0];
         period_wr  = tbl[r].pw[0];
         period_in  = CNT_W'(tbl[r].pin);
         ch_arm     = 2'(tbl[r].arm);
         for (int k = 0; k < tbl[r].n; k++) begin
            cycle();
            restart = 1'b0; period_wr = 1'b0; ch_arm = '0;
         end
         check($sformatf("row%0d base_tick count", r), seen_bt, tbl[r].bt);
         check($sformatf("row%0d ch_tick0 count", r), seen_c0, tbl[r].c0);
         check($sformatf("row%0d ch_tick1 count", r), seen_c1, tbl[r].c1);
         if (r == 6)
            check("frame_count after 35 cycles", int'(frame_count), FC_EN ? 3 : 0);
      end

      // random traffic against the model
      for (int k = 0; k < 600; k++) begin
         enable    = ($urandom_range(0, 9) != 0);
         restart   = ($urandom_range(0, 80) == 0);
         period_wr = ($urandom_range(0, 40) == 0);
         period_in = CNT_W'($urandom_range(0, 6));
         ch_arm    = {($urandom_range(0, 30) == 0), ($urandom_range(0, 30) == 0)};
         if ($urandom_range(0, 25) == 0) ch_div = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 40) == 0) ch_oneshot = 2'($urandom_range(0, 3));
         cycle();
      end
      restart = 1'b0; period_wr = 1'b0; ch_arm = '0;

      // reset mid-period discards partial counts and restores PERIOD
      enable = 1'b1; ch_div = '0; ch_oneshot = '0;
      repeat (4) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("post-reset fc", int'(frame_count), 0);
      seen_bt = 0;
      repeat (9) cycle();
      check("post-reset no early tick", seen_bt, 0);
      cycle();
      check("post-reset tick at 10", int'(base_tick), 1);

      check("scoreboard drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
